bldc_drive_sequencer: RTL



---
 rtl/bldc_pkg.sv | 24 ++
 rtl/bldc_drive_sequencer_if.sv | 28 ++
 rtl/bldc_enc_activity.sv | 32 +++
 rtl/bldc_drive_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bldc_pkg.sv
// Shared run-level encodings for the BLDC drive path.
// Latency: n/a (types, constants and a pure helper function).
// Backpressure: n/a.
package bldc_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RAMP     = 3'd1,
      RUN      = 3'd2,
      STOPPING = 3'd3,
      DWELL    = 3'd4,
      FAULT    = 3'd5
   } state_t;

   // Bridge direction codes; 2'b11 would turn on both half-bridges and is never produced.
   localparam logic [1:0] DIR_OFF = 2'b00;
   localparam logic [1:0] DIR_FWD = 2'b10;
   localparam logic [1:0] DIR_REV = 2'b01;

   function automatic logic [1:0] dir_code(input logic rev);
      return rev ? DIR_REV : DIR_FWD;
   endfunction

endpackage

// File: rtl/bldc_drive_sequencer_if.sv
// Command/status bundle between host logic, the sequencer and the drive stage.
// Latency: n/a (wiring only).
// Backpressure: none; run_en is a level and the status outputs are always valid.
interface bldc_drive_sequencer_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  run_en;
   logic                  dir_req;
   logic [DATA_WIDTH-1:0] target_duty;
   logic                  encoder_a;
   logic                  encoder_b;
   logic                  clear_fault;
   logic [DATA_WIDTH-1:0] duty_cmd;
   logic [1:0]            dir_cmd;
   logic                  busy;
   logic                  fault;
   logic [2:0]            state_o;

   modport master (
      output run_en, dir_req, target_duty, encoder_a, encoder_b, clear_fault,
      input  duty_cmd, dir_cmd, busy, fault, state_o
   );

   modport slave (
      input  run_en, dir_req, target_duty, encoder_a, encoder_b, clear_fault,
      output duty_cmd, dir_cmd, busy, fault, state_o
   );
endinterface

// File: rtl/bldc_enc_activity.sv
// Encoder activity detector: two-flop synchronizer per channel plus change detect.
// Latency: an input change shows up on enc_edge 2 clocks later, for one clock.
// Backpressure: none; enc_edge is a single-cycle pulse.
module bldc_enc_activity (
   input  logic clk,
   input  logic reset,
   input  logic encoder_a,
   input  logic encoder_b,
   output logic enc_edge
);

   logic [1:0] meta;
   logic [1:0] sync;
   logic [1:0] prev;

   // Synchronize both channels and keep last cycle's value for change detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 2'b00;
         sync <= 2'b00;
         prev <= 2'b00;
      end else begin
         meta <= {encoder_a, encoder_b};
         sync <= meta;
         prev <= sync;
      end
   end

   // Any change on either synchronized channel counts as motion.
   assign enc_edge = (sync != prev);

endmodule

// File: rtl/bldc_drive_sequencer.sv
// Run-level sequencer: soft-start ramp, run, ramp-down, dead-time dwell, stall fault.
// Latency: one clock from a run/stop/direction request to the state change; duty moves 1 LSB per RAMP_DIV clocks.
// Backpressure: none; requests are levels and are re-evaluated every clock.
module bldc_drive_sequencer
   import bldc_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int DUTY_MAX    = 16,
   parameter int RAMP_DIV    = 4,
   parameter int DEAD_CYCLES = 8,
   parameter int STALL_LIMIT = 1000
) (
   input logic                    clk,
   input logic                    reset,
   bldc_drive_sequencer_if.slave  bus
);

   localparam logic [DATA_WIDTH-1:0] DUTY_LIM   = DATA_WIDTH'(DUTY_MAX);
   localparam logic [DATA_WIDTH-1:0] TICK_LAST  = DATA_WIDTH'(RAMP_DIV - 1);
   localparam logic [DATA_WIDTH-1:0] DWELL_LAST = DATA_WIDTH'(DEAD_CYCLES - 1);
   localparam logic [DATA_WIDTH-1:0] STALL_LAST = DATA_WIDTH'(STALL_LIMIT - 1);

   state_t                state;
   logic [DATA_WIDTH-1:0] duty;
   logic [1:0]            drive_dir;
   logic                  busy_flag;
   logic                  fault_flag;
   logic                  dir_lat;
   logic                  rev_pend;
   logic [DATA_WIDTH-1:0] tick_cnt;
   logic [DATA_WIDTH-1:0] dwell_cnt;
   logic [DATA_WIDTH-1:0] stall_cnt;
   logic [DATA_WIDTH-1:0] tgt;
   logic                  ramp_tick;
   logic                  enc_edge;

   bldc_enc_activity u_enc (
      .clk       (clk),
      .reset     (reset),
      .encoder_a (bus.encoder_a),
      .encoder_b (bus.encoder_b),
      .enc_edge  (enc_edge)
   );

   // Requested duty clamped to the PWM range.
   always_comb begin
      tgt = bus.target_duty;
      if (bus.target_duty > DUTY_LIM) tgt = DUTY_LIM;
   end

   assign ramp_tick = ((state == RAMP) || (state == STOPPING)) && (tick_cnt == TICK_LAST);

   // Main sequencer: state, duty, direction and status are all registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         duty       <= '0;
         drive_dir  <= DIR_OFF;
         busy_flag  <= 1'b0;
         fault_flag <= 1'b0;
         dir_lat    <= 1'b0;
         rev_pend   <= 1'b0;
         tick_cnt   <= '0;
         dwell_cnt  <= '0;
         stall_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               duty      <= '0;
               drive_dir <= DIR_OFF;
               if (bus.run_en) begin
                  dir_lat   <= bus.dir_req;
                  drive_dir <= dir_code(bus.dir_req);
                  tick_cnt  <= '0;
                  busy_flag <= 1'b1;
                  state     <= RAMP;
               end
            end

            RAMP: begin
               if (!bus.run_en) begin
                  tick_cnt <= '0;
                  state    <= STOPPING;
               end else if (bus.dir_req != dir_lat) begin
                  rev_pend <= 1'b1;
                  tick_cnt <= '0;
                  state    <= STOPPING;
               end else if (duty == tgt) begin
                  stall_cnt <= '0;
                  state     <= RUN;
               end else begin
                  tick_cnt <= ramp_tick ? '0 : tick_cnt + 1'b1;
                  if (ramp_tick) duty <= (duty < tgt) ? duty + 1'b1 : duty - 1'b1;
               end
            end

            RUN: begin
               if (!enc_edge && (stall_cnt == STALL_LAST)) begin
                  // No motion for the full stall window: kill the bridge and latch the fault.
                  duty       <= '0;
                  drive_dir  <= DIR_OFF;
                  fault_flag <= 1'b1;
                  busy_flag  <= 1'b0;
                  stall_cnt  <= '0;
                  state      <= FAULT;
               end else begin
                  stall_cnt <= enc_edge ? '0 : stall_cnt + 1'b1;
                  if (!bus.run_en) begin
                     tick_cnt <= '0;
                     state    <= STOPPING;
                  end else if (bus.dir_req != dir_lat) begin
                     rev_pend <= 1'b1;
                     tick_cnt <= '0;
                     state    <= STOPPING;
                  end else if (tgt != duty) begin
                     tick_cnt <= '0;
                     state    <= RAMP;
                  end
               end
            end

            STOPPING: begin
               // Direction stays driven until duty is fully ramped to zero.
               if (duty == '0) begin
                  drive_dir <= DIR_OFF;
                  dwell_cnt <= '0;
                  state     <= DWELL;
               end else begin
                  tick_cnt <= ramp_tick ? '0 : tick_cnt + 1'b1;
                  if (ramp_tick) duty <= duty - 1'b1;
               end
            end

            DWELL: begin
               if (dwell_cnt == DWELL_LAST) begin
                  dwell_cnt <= '0;
                  tick_cnt  <= '0;
                  if (bus.run_en && rev_pend) begin
                     // Re-latch here so a request toggled back during ramp-down is harmless.
                     dir_lat   <= bus.dir_req;
                     drive_dir <= dir_code(bus.dir_req);
                     rev_pend  <= 1'b0;
                     state     <= RAMP;
                  end else if (bus.run_en) begin
                     drive_dir <= dir_code(dir_lat);
                     state     <= RAMP;
                  end else begin
                     rev_pend  <= 1'b0;
                     busy_flag <= 1'b0;
                     state     <= IDLE;
                  end
               end else begin
                  dwell_cnt <= dwell_cnt + 1'b1;
               end
            end

            FAULT: begin
               duty      <= '0;
               drive_dir <= DIR_OFF;
               // Clearing only with the run request withdrawn prevents an immediate restart.
               if (bus.clear_fault && !bus.run_en) begin
                  fault_flag <= 1'b0;
                  rev_pend   <= 1'b0;
                  state      <= IDLE;
               end
            end

            default: begin
               duty      <= '0;
               drive_dir <= DIR_OFF;
               busy_flag <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.duty_cmd = duty;
   assign bus.dir_cmd  = drive_dir;
   assign bus.busy     = busy_flag;
   assign bus.fault    = fault_flag;
   assign bus.state_o  = state;

endmodule
